// File: rtl/piso_scan_reader_if.sv
// Bundle between the scan reader, the external PISO register and the consumer.
// master = reader side, slave = register/consumer side.
interface piso_scan_reader_if #(
  parameter int BITS = 8
);
  logic            START;
  logic            CONT;
  logic            SH_LD;
  logic            CLK_INH;
  logic            QH;
  logic            QHb;
  logic [BITS-1:0] DATA;
  logic            VALID;
  logic            READY;
  logic            BUSY;
  logic            ERR;
  logic            ERR_CLR;

  modport master (
    input  START, CONT, QH, QHb, READY, ERR_CLR,
    output SH_LD, CLK_INH, DATA, VALID, BUSY, ERR
  );

  modport slave (
    output START, CONT, QH, QHb, READY, ERR_CLR,
    input  SH_LD, CLK_INH, DATA, VALID, BUSY, ERR
  );
endinterface

// File: rtl/piso_scan_reader.sv
// Drives SH_LD/CLK_INH of a cascaded PISO shift register, reassembles the
// serial word from QH and hands it out over VALID/READY.
module piso_scan_reader #(
  parameter int BITS     = 8,
  parameter int LOAD_CYC = 1,
  parameter int GAP      = 0
) (
  input logic                CLK,
  input logic                RST_N,
  piso_scan_reader_if.master bus
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BITS - 1);
  localparam logic [3:0]    LD_LAST  = 4'(LOAD_CYC - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_bit;
  logic [3:0]      r_ld;
  logic [7:0]      r_gap;
  logic [BITS-1:0] r_data;
  logic            r_sh_ld;
  logic            r_clk_inh;
  logic            r_valid;
  logic            r_busy;
  logic            r_err;
  logic            w_err_hit;

  assign w_err_hit = (r_state == S_SHIFT) &&
                     (bus.QH == bus.QHb);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_bit     <= '0;
      r_ld      <= '0;
      r_gap     <= '0;
      r_data    <= '0;
      r_sh_ld   <= 1'b1;
      r_clk_inh <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // a fault seen on the same edge as a clear must not be lost
      if (w_err_hit)
        r_err <= 1'b1;
      else if (bus.ERR_CLR)
        r_err <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.START || bus.CONT) begin
            r_state <= S_LOAD;
            r_sh_ld <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (r_ld == LD_LAST) begin
            r_ld    <= '0;
            r_state <= S_SETTLE;
            r_sh_ld <= 1'b1;
          end else begin
            r_ld <= r_ld + 4'd1;
          end
        end
        S_SETTLE: begin
          r_state   <= S_SHIFT;
          r_clk_inh <= 1'b0;
        end
        S_SHIFT: begin
          r_data <= {r_data[BITS-2:0], bus.QH};
          if (r_bit == BIT_LAST) begin
            r_bit     <= '0;
            r_state   <= S_HOLD;
            r_clk_inh <= 1'b1;
            r_valid   <= 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.READY) begin
            r_valid <= 1'b0;
            if (!bus.CONT) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (GAP > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_LOAD;
              r_sh_ld <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_gap   <= '0;
            r_state <= S_LOAD;
            r_sh_ld <= 1'b0;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_sh_ld   <= 1'b1;
          r_clk_inh <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SH_LD   = r_sh_ld;
  assign bus.CLK_INH = r_clk_inh;
  assign bus.DATA    = r_data;
  assign bus.VALID   = r_valid;
  assign bus.BUSY    = r_busy;
  assign bus.ERR     = r_err;

endmodule

// File: tb/tb_piso_scan_reader.sv
// Bench: two readers (8-bit, GAP=2 and 16-bit cascade, GAP=0) each fed by a
// behavioural PISO register; expected words are the loaded parallel values.
module tb_piso_scan_reader;

  localparam int LA = 1;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  int passed  = 0;
  int total   = 0;
  int overlap = 0;

  piso_scan_reader_if #(.BITS(8))  ba();
  piso_scan_reader_if #(.BITS(16)) bb();

  piso_scan_reader #(.BITS(8), .LOAD_CYC(1), .GAP(2)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(ba.master)
  );
  piso_scan_reader #(.BITS(16), .LOAD_CYC(1), .GAP(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(bb.master)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  pa  = '0;
  logic [7:0]  sra = '0;
  logic        fa  = 1'b0;
  logic [15:0] pb  = '0;
  logic [15:0] srb = '0;

  // PISO register models: load while SH_LD low, shift when clock enabled
  always @(posedge CLK) begin
    if (!ba.SH_LD) sra <= pa;
    else if (!ba.CLK_INH) sra <= {sra[6:0], 1'b0};
    if (!bb.SH_LD) srb <= pb;
    else if (!bb.CLK_INH) srb <= {srb[14:0], 1'b0};
  end

  assign ba.QH  = sra[7];
  assign ba.QHb = fa ? sra[7] : ~sra[7];
  assign bb.QH  = srb[15];
  assign bb.QHb = ~srb[15];

  always @(negedge CLK) begin
    if (RST_N && !ba.SH_LD && !ba.CLK_INH) overlap++;
    if (RST_N && !bb.SH_LD && !bb.CLK_INH) overlap++;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic accept_a;
    ba.READY = 1'b1;
    tick();
    ba.READY = 1'b0;
  endtask

  task automatic scan_a(input logic [7:0] w, input int fbit,
                        input bit fclr, output int lat,
                        output int nld, output int ninh);
    pa = w;
    ba.START = 1'b1;
    tick();
    ba.START = 1'b0;
    lat = 0; nld = 0; ninh = 0;
    while (!ba.VALID && lat < 40) begin
      if (!ba.SH_LD) nld++;
      if (!ba.CLK_INH) ninh++;
      fa = (fbit >= 0) && (lat == LA + 1 + fbit);
      ba.ERR_CLR = fa & fclr;
      tick();
      lat++;
    end
    fa = 1'b0;
    ba.ERR_CLR = 1'b0;
  endtask

  task automatic scan_b(input logic [15:0] w, output int lat);
    pb = w;
    bb.START = 1'b1;
    tick();
    bb.START = 1'b0;
    lat = 0;
    while (!bb.VALID && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    #2 RST_N = 1'b0;
    #1;
    total++;
    if ({ba.SH_LD, ba.CLK_INH, ba.VALID, ba.BUSY, ba.ERR} !== 5'b11000 ||
        ba.DATA !== 8'h00) begin
      $display("FAIL reset_a: ctl=%b data=%h want ctl=11000 data=00",
               {ba.SH_LD, ba.CLK_INH, ba.VALID, ba.BUSY, ba.ERR}, ba.DATA);
    end else passed++;
    total++;
    if ({bb.SH_LD, bb.CLK_INH, bb.VALID, bb.BUSY, bb.ERR} !== 5'b11000 ||
        bb.DATA !== 16'h0) begin
      $display("FAIL reset_b: ctl=%b data=%h want ctl=11000 data=0000",
               {bb.SH_LD, bb.CLK_INH, bb.VALID, bb.BUSY, bb.ERR}, bb.DATA);
    end else passed++;
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single;
    int lat, nld, ninh;
    scan_a(8'hD5, -1, 1'b0, lat, nld, ninh);
    total++;
    if (lat !== LA + 1 + 8) $display("FAIL single_lat: got %0d want %0d", lat, LA + 9);
    else passed++;
    total++;
    if (nld !== LA || ninh !== 8)
      $display("FAIL single_ctl: ld=%0d inh=%0d want %0d 8", nld, ninh, LA);
    else passed++;
    total++;
    if (ba.DATA !== 8'hD5 || ba.BUSY !== 1'b1)
      $display("FAIL single_data: data=%h busy=%b want d5 1", ba.DATA, ba.BUSY);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      ba.START = (i == 2);
      tick();
      total++;
      if (ba.VALID !== 1'b1 || ba.DATA !== 8'hD5)
        $display("FAIL backpressure: valid=%b data=%h want 1 d5", ba.VALID, ba.DATA);
      else passed++;
    end
    ba.START = 1'b0;
    accept_a();
    total++;
    if (ba.VALID !== 1'b0 || ba.BUSY !== 1'b0)
      $display("FAIL accept: valid=%b busy=%b want 0 0", ba.VALID, ba.BUSY);
    else passed++;
    repeat (3) tick();
    total++;
    if (ba.BUSY !== 1'b0) $display("FAIL start_in_hold: busy=%b want 0", ba.BUSY);
    else passed++;
  endtask

  task automatic test_random_scans;
    int lat, nld, ninh, d;
    logic [7:0] w;
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      d = $urandom_range(0, 4);
      ba.READY = i[0];
      scan_a(w, -1, 1'b0, lat, nld, ninh);
      total++;
      if (lat !== LA + 9 || ba.DATA !== w)
        $display("FAIL rand_scan: lat=%0d data=%h want %0d %h", lat, ba.DATA, LA + 9, w);
      else passed++;
      if (!ba.READY) repeat (d) tick();
      ba.READY = 1'b1;
      tick();
      ba.READY = 1'b0;
      total++;
      if (ba.VALID !== 1'b0 || ba.BUSY !== 1'b0)
        $display("FAIL rand_accept: valid=%b busy=%b want 0 0", ba.VALID, ba.BUSY);
      else passed++;
    end
  endtask

  task automatic test_reset_midshift;
    int nv;
    int lat, nld, ninh;
    logic [7:0] w;
    pa = 8'($urandom) | 8'hE0;
    ba.START = 1'b1;
    tick();
    ba.START = 1'b0;
    repeat (LA + 4) tick();
    #2 RST_N = 1'b0;
    #1;
    total++;
    if ({ba.SH_LD, ba.CLK_INH, ba.VALID, ba.BUSY} !== 4'b1100 || ba.DATA !== 8'h00)
      $display("FAIL reset_mid: ctl=%b data=%h want 1100 00",
               {ba.SH_LD, ba.CLK_INH, ba.VALID, ba.BUSY}, ba.DATA);
    else passed++;
    #1 RST_N = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ba.VALID) nv++;
    end
    total++;
    if (nv !== 0 || ba.BUSY !== 1'b0)
      $display("FAIL reset_partial: valids=%0d busy=%b want 0 0", nv, ba.BUSY);
    else passed++;
    w = 8'($urandom);
    scan_a(w, -1, 1'b0, lat, nld, ninh);
    total++;
    if (lat !== LA + 9 || ba.DATA !== w)
      $display("FAIL reset_rescan: lat=%0d data=%h want %0d %h", lat, ba.DATA, LA + 9, w);
    else passed++;
    accept_a();
  endtask

  task automatic test_continuous;
    logic [7:0] q[$];
    logic [7:0] w;
    int t, last, nv;
    pa = 8'h86;
    q.push_back(8'h86);
    ba.READY = 1'b1;
    ba.CONT  = 1'b1;
    t = 0; last = -1; nv = 0;
    while (nv < 5 && t < 200) begin
      tick();
      t++;
      if (ba.VALID) begin
        total++;
        if (ba.DATA !== q[0]) $display("FAIL cont_data: got %h want %h", ba.DATA, q[0]);
        else passed++;
        void'(q.pop_front());
        if (last >= 0) begin
          total++;
          if (t - last !== 13) $display("FAIL cont_period: got %0d want 13", t - last);
          else passed++;
        end
        last = t;
        nv++;
        w = 8'($urandom);
        pa = w;
        q.push_back(w);
      end
    end
    total++;
    if (nv !== 5) $display("FAIL cont_timeout: got %0d words want 5", nv);
    else passed++;
    repeat (6) tick();
    ba.CONT = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ba.VALID) begin
        nv++;
        total++;
        if (ba.DATA !== q[0]) $display("FAIL cont_last: got %h want %h", ba.DATA, q[0]);
        else passed++;
      end
    end
    total++;
    if (nv !== 1 || ba.BUSY !== 1'b0)
      $display("FAIL cont_stop: words=%0d busy=%b want 1 0", nv, ba.BUSY);
    else passed++;
    ba.READY = 1'b0;
  endtask

  task automatic test_err;
    int lat, nld, ninh;
    logic [7:0] w;
    w = 8'($urandom);
    scan_a(w, $urandom_range(0, 7), 1'b0, lat, nld, ninh);
    total++;
    if (ba.ERR !== 1'b1 || ba.DATA !== w)
      $display("FAIL err_set: err=%b data=%h want 1 %h", ba.ERR, ba.DATA, w);
    else passed++;
    accept_a();
    w = 8'($urandom);
    scan_a(w, -1, 1'b0, lat, nld, ninh);
    total++;
    if (ba.ERR !== 1'b1) $display("FAIL err_sticky: got %b want 1", ba.ERR);
    else passed++;
    accept_a();
    ba.ERR_CLR = 1'b1;
    tick();
    ba.ERR_CLR = 1'b0;
    total++;
    if (ba.ERR !== 1'b0) $display("FAIL err_clr: got %b want 0", ba.ERR);
    else passed++;
    scan_a(8'($urandom), 5, 1'b1, lat, nld, ninh);
    total++;
    if (ba.ERR !== 1'b1) $display("FAIL err_set_wins: got %b want 1", ba.ERR);
    else passed++;
    accept_a();
    ba.ERR_CLR = 1'b1;
    tick();
    ba.ERR_CLR = 1'b0;
    scan_a(8'($urandom), -1, 1'b0, lat, nld, ninh);
    total++;
    if (ba.ERR !== 1'b0) $display("FAIL err_clean: got %b want 0", ba.ERR);
    else passed++;
    accept_a();
  endtask

  task automatic test_cascade;
    int lat;
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 16'hC526 : 16'($urandom);
      scan_b(w, lat);
      total++;
      if (lat !== LA + 1 + 16 || bb.DATA !== w)
        $display("FAIL cascade: lat=%0d data=%h want %0d %h", lat, bb.DATA, LA + 17, w);
      else passed++;
      bb.READY = 1'b1;
      tick();
      bb.READY = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q[$];
    logic [15:0] w;
    int t, last, nv;
    w = 16'($urandom);
    pb = w;
    q.push_back(w);
    bb.READY = 1'b1;
    bb.CONT  = 1'b1;
    t = 0; last = -1; nv = 0;
    while (nv < 4 && t < 200) begin
      tick();
      t++;
      if (bb.VALID) begin
        total++;
        if (bb.DATA !== q[0]) $display("FAIL b2b_data: got %h want %h", bb.DATA, q[0]);
        else passed++;
        void'(q.pop_front());
        if (last >= 0) begin
          total++;
          if (t - last !== 19) $display("FAIL b2b_period: got %0d want 19", t - last);
          else passed++;
        end
        last = t;
        nv++;
        w = 16'($urandom);
        pb = w;
        q.push_back(w);
      end
    end
    bb.CONT = 1'b0;
    t = 0;
    while (bb.BUSY && t < 60) begin
      tick();
      t++;
    end
    total++;
    if (nv !== 4 || bb.BUSY !== 1'b0)
      $display("FAIL b2b_end: words=%0d busy=%b want 4 0", nv, bb.BUSY);
    else passed++;
    bb.READY = 1'b0;
  endtask

  task automatic test_overlap;
    total++;
    if (overlap !== 0) $display("FAIL ctl_overlap: got %0d want 0", overlap);
    else passed++;
  endtask

  initial begin
    ba.START = 1'b0; ba.CONT = 1'b0; ba.READY = 1'b0; ba.ERR_CLR = 1'b0;
    bb.START = 1'b0; bb.CONT = 1'b0; bb.READY = 1'b0; bb.ERR_CLR = 1'b0;
    test_reset();
    test_single();
    test_random_scans();
    test_reset_midshift();
    test_continuous();
    test_err();
    test_cascade();
    test_back_to_back();
    test_overlap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/piso_scan_reader.md
Name: piso_scan_reader

Overview:
- Downstream companion to the 8-bit parallel-in/serial-out shift register (SH_LD / CLK_INH / QH / QHb device).
- Drives the register's load and clock-inhibit controls on the shared CLK and samples QH serially.
- Reassembles the parallel word and presents it through a VALID/READY handshake to the consumer logic.
- Supports single-shot scans on START and continuous back-to-back scanning, plus a QH/QHb integrity check.

Parameters:
- BITS, 8, total serial chain length in bits (8 per cascaded register); 2..64.
- LOAD_CYC, 1, number of cycles SH_LD is held low; 1..15.
- GAP, 0, idle cycles between scans in continuous mode; 0..255.

Ports:
- CLK  in  1  system clock, shared with the shift register; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle scan request; sampled in IDLE only.
- CONT  in  1  continuous mode: rescan automatically after each handshake.
- SH_LD  out  1  to register: 0 = parallel load, 1 = shift.
- CLK_INH  out  1  to register: 1 = clock inhibited.
- QH  in  1  serial data from the register.
- QHb  in  1  complementary serial data from the register.
- DATA  out  BITS  assembled word; first bit received goes to DATA[BITS-1].
- VALID  out  1  DATA holds a complete word.
- READY  in  1  consumer accepts DATA when VALID & READY at a rising edge.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky flag, set when QH == QHb is sampled during SHIFT.
- ERR_CLR  in  1  synchronous clear for ERR.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-scan):
  - SH_LD=1, CLK_INH=1, DATA=0, VALID=0, BUSY=0, ERR=0.
  - State=IDLE; all counters = 0.
  - No partial word is ever presented after reset.
- States:
  - IDLE: SH_LD=1, CLK_INH=1.
    - START=1 or CONT=1 -> LOAD.
  - LOAD: SH_LD=0, CLK_INH=1 for exactly LOAD_CYC cycles -> SETTLE.
  - SETTLE: one cycle, SH_LD=1, CLK_INH=1. The register output is now the H bit -> SHIFT.
  - SHIFT: SH_LD=1, CLK_INH=0 for exactly BITS cycles.
    - Each edge: DATA <= {DATA[BITS-2:0], QH}, i.e. the pre-shift QH value.
    - The extra register shift on the final edge is harmless.
    - On the edge ending cycle BITS: state -> HOLD and VALID <= 1 on that same edge.
    - Bit counter width: clog2(BITS+1).
  - HOLD: CLK_INH=1, VALID=1, DATA frozen.
    - On an edge with READY=1: VALID <= 0.
    - Then next state = GAP if CONT=1 and GAP>0; LOAD if CONT=1 and GAP=0; otherwise IDLE.
    - If READY is already high when VALID rises, the transfer completes on the first HOLD edge, so VALID lasts one cycle.
  - GAP: SH_LD=1, CLK_INH=1 for GAP cycles -> LOAD.
- Latency: the edge sampling START, plus LOAD_CYC+1+BITS cycles, gives VALID high. Defaults: 10 cycles.
- START is ignored outside IDLE (no queuing).
- CONT is sampled only in IDLE and at HOLD exit. Dropping CONT mid-scan completes the current scan and handshake, then returns to IDLE.
- ERR:
  - Set on any SHIFT edge where QH == QHb.
  - Cleared by ERR_CLR=1; if set and clear occur on the same edge, set wins.
  - ERR does not abort the scan.
- SH_LD and CLK_INH are never both low at the same time.

Test Plan:
- Reset mid-SHIFT: pulse RST_N low during bit 3 -> outputs immediately SH_LD=1, CLK_INH=1, VALID=0, DATA=0. After release, START scans normally.
- Single scan, defaults: register loaded A..H = 1,0,1,0,1,0,1,1, START pulse -> SH_LD low 1 cycle, then CLK_INH low 8 cycles, then VALID=1 with DATA=8'hD5 exactly 10 cycles after the START edge.
- Back-pressure: READY=0 for 5 cycles after VALID -> DATA stays 8'hD5 and VALID stays high; READY=1 -> VALID drops the next edge and the FSM returns to IDLE. A START pulsed during HOLD is ignored.
- Continuous, GAP=2: CONT=1, READY tied 1, parallel inputs B=C=H=1 (others 0) -> repeated DATA=8'h86. Between VALID pulses: 1 HOLD + 2 GAP + 1 LOAD + 1 SETTLE + 8 SHIFT = 13-cycle period. Dropping CONT mid-scan gives exactly one more word, then IDLE.
- Integrity: force QHb=QH during bit 5 -> ERR=1 and stays high across scans. Assert ERR_CLR and a forced fault on the same edge -> ERR stays 1. ERR_CLR alone -> ERR=0.
- Cascade: BITS=16, two registers loaded 8'hC5 (first out) then 8'h26 -> DATA=16'hC526, VALID 18 cycles after START.
